sub_operand_sequencer: RTL and testbench
========================================

Name: sub_operand_sequencer

Overview:
- Upstream issue stage for the pipelined subtractor.
- The subtractor's din2 path contains a register, so din1 and din2 must be held stable until its output settles.
- This block accepts an operand pair over a valid/ready handshake and holds both operands on the subtractor inputs for the settle window.
- It then captures the subtractor result, adds borrow/zero flags, and presents the result downstream over a second valid/ready handshake.

Parameters:
DWIDTH, 8, operand/result width; must match the attached subtractor.
SETTLE_CYCLES, 1, clock edges after operand launch before sub_dout is valid; legal range 1..15.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  upstream operand pair valid.
in_ready  output  1  block can accept a pair this cycle.
in_a  input  DWIDTH  minuend.
in_b  input  DWIDTH  subtrahend.
sub_din1  output  DWIDTH  registered minuend driven to the subtractor.
sub_din2  output  DWIDTH  registered subtrahend driven to the subtractor.
sub_dout  input  DWIDTH  difference returned by the subtractor.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
out_diff  output  DWIDTH  captured difference.
out_borrow  output  1  1 when in_a < in_b (unsigned).
out_zero  output  1  1 when out_diff == 0.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE; the settle counter clears.
  - sub_din1, sub_din2, out_diff, out_borrow, out_zero, out_valid are all 0.
  - in_ready is 1 while in IDLE.
- States:
  - IDLE: in_ready=1. When in_valid is high at an edge: latch in_a into sub_din1 and in_b into sub_din2, compute and hold borrow = (in_a < in_b), load counter with SETTLE_CYCLES, go to WAIT.
  - WAIT: in_ready=0; operands are held.
    - At each edge with counter != 0, decrement the counter.
    - At the edge where counter == 0: capture sub_dout into out_diff; set out_zero = (sub_dout == 0); copy the held borrow into out_borrow; set out_valid=1; go to DONE.
  - DONE: out_valid=1; out_diff and flags are held stable until the handshake completes.
    - out_ready=1 with in_valid=0: out_valid drops to 0 at that edge; go to IDLE.
    - out_ready=1 with in_valid=1: result retires and the new pair is launched at the same edge (as in IDLE); go to WAIT.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is combinational from out_ready; there is no combinational path from in_valid.
- Latency: out_valid rises SETTLE_CYCLES+1 edges after the accepting edge. With the default this is 2 edges. Peak throughput is one result per SETTLE_CYCLES+2 cycles.
- Operand hold: sub_din1 and sub_din2 change only at an accepting edge. They remain stable through WAIT and DONE, and after returning to IDLE.
- Arithmetic:
  - Difference is modulo 2^DWIDTH and comes from the subtractor only; the block does not recompute it.
  - Borrow is computed locally as an unsigned compare.
- Flags and out_diff are meaningful only while out_valid=1. They retain their last value otherwise.
- in_valid is ignored in WAIT; upstream must hold it until in_ready.
- Reset asserted in WAIT or DONE discards the in-flight operation; no partial result is presented.
- out_ready while out_valid=0 has no effect.

Test Plan:
1. Reset: assert rst mid-cycle -> all outputs 0 immediately; after release in_ready=1, out_valid=0.
2. Single op, DWIDTH=8: a=8'd100, b=8'd37 accepted at edge 0 -> out_valid at edge 2; out_diff=63, out_borrow=0, out_zero=0; sub_din1/sub_din2 stay 100/37 throughout.
3. Wrap and zero:
   - a=5, b=9 -> out_diff=8'd252, out_borrow=1.
   - a=0x5A, b=0x5A -> out_diff=0, out_zero=1, out_borrow=0.
4. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid and out_diff held constant, in_ready=0, a new in_valid is not accepted. When out_ready=1, the result retires in one edge.
5. Back-to-back: in_valid held with pairs (200,1),(3,4); out_ready=1 -> second pair accepted at the same edge the first result retires; outputs 199 then 255 with borrow=1; interval 3 cycles.
6. Reset mid-WAIT with SETTLE_CYCLES=3: accept (10,2), assert rst after one edge -> out_valid never asserts. After release, (7,7) yields out_zero=1 four edges after acceptance.

Source files
------------

// File: rtl/sub_operand_sequencer.sv
// sub_operand_sequencer
//   Issue stage in front of a pipelined subtractor. Accepts an operand pair
//   over a valid/ready handshake and holds it on the subtractor inputs for
//   the settle window. It then captures the returned difference, adds
//   borrow/zero flags, and offers the result downstream over a second
//   valid/ready handshake.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    upstream handshake for the operand pair
//   in_a, in_b           minuend / subtrahend
//   sub_din1, sub_din2   operands held on the subtractor inputs
//   sub_dout             difference returned by the subtractor
//   out_valid/out_ready  downstream handshake for the result
//   out_diff             captured difference
//   out_borrow           in_a < in_b (unsigned)
//   out_zero             out_diff == 0
module sub_operand_sequencer #(
  parameter int DWIDTH        = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_a,
  input  logic [DWIDTH-1:0] in_b,
  output logic [DWIDTH-1:0] sub_din1,
  output logic [DWIDTH-1:0] sub_din2,
  input  logic [DWIDTH-1:0] sub_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_diff,
  output logic              out_borrow,
  output logic              out_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  state_t            state_r, state_nxt_s;
  logic [3:0]        cnt_r, cnt_nxt_s;
  logic [DWIDTH-1:0] din1_r, din1_nxt_s;
  logic [DWIDTH-1:0] din2_r, din2_nxt_s;
  logic              borrow_hold_r, borrow_hold_nxt_s;
  logic              valid_r, valid_nxt_s;
  logic [DWIDTH-1:0] diff_r, diff_nxt_s;
  logic              borrow_r, borrow_nxt_s;
  logic              zero_r, zero_nxt_s;
  logic              in_ready_s;

  // State and datapath registers; async reset discards any in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= 4'd0;
      din1_r        <= {DWIDTH{1'b0}};
      din2_r        <= {DWIDTH{1'b0}};
      borrow_hold_r <= 1'b0;
      valid_r       <= 1'b0;
      diff_r        <= {DWIDTH{1'b0}};
      borrow_r      <= 1'b0;
      zero_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      din1_r        <= din1_nxt_s;
      din2_r        <= din2_nxt_s;
      borrow_hold_r <= borrow_hold_nxt_s;
      valid_r       <= valid_nxt_s;
      diff_r        <= diff_nxt_s;
      borrow_r      <= borrow_nxt_s;
      zero_r        <= zero_nxt_s;
    end
  end

  // Next-state, settle countdown, result capture and operand launch.
  always_comb begin
    state_nxt_s       = state_r;
    cnt_nxt_s         = cnt_r;
    din1_nxt_s        = din1_r;
    din2_nxt_s        = din2_r;
    borrow_hold_nxt_s = borrow_hold_r;
    valid_nxt_s       = valid_r;
    diff_nxt_s        = diff_r;
    borrow_nxt_s      = borrow_r;
    zero_nxt_s        = zero_r;
    in_ready_s        = 1'b0;

    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
      end
      WAIT: begin
        if (cnt_r != 4'd0) begin
          cnt_nxt_s = cnt_r - 4'd1;
        end else begin
          diff_nxt_s   = sub_dout;
          zero_nxt_s   = (sub_dout == {DWIDTH{1'b0}});
          borrow_nxt_s = borrow_hold_r;
          valid_nxt_s  = 1'b1;
          state_nxt_s  = DONE;
        end
      end
      DONE: begin
        // Retiring frees the block this same cycle, so a waiting pair can
        // launch on the retiring edge (combinational from out_ready only).
        if (out_ready) begin
          in_ready_s  = 1'b1;
          valid_nxt_s = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          in_ready_s  = 1'b0;
        end
      end
      default: begin
        valid_nxt_s = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase

    // Launch overrides the IDLE return chosen above when a pair is waiting.
    if (in_valid && in_ready_s) begin
      din1_nxt_s        = in_a;
      din2_nxt_s        = in_b;
      borrow_hold_nxt_s = (in_a < in_b);
      cnt_nxt_s         = SETTLE_LD;
      state_nxt_s       = WAIT;
    end else begin
      din1_nxt_s        = din1_nxt_s;
    end
  end

  assign in_ready   = in_ready_s;
  assign sub_din1   = din1_r;
  assign sub_din2   = din2_r;
  assign out_valid  = valid_r;
  assign out_diff   = diff_r;
  assign out_borrow = borrow_r;
  assign out_zero   = zero_r;

endmodule

// File: tb/tb_sub_operand_sequencer.sv
module tb_sub_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst, rst1;

  // Instance with default settle window
  logic       in_valid, in_ready, out_valid, out_ready, out_borrow, out_zero;
  logic [7:0] in_a, in_b, sub_din1, sub_din2, sub_dout, out_diff;

  // Instance with SETTLE_CYCLES = 3
  logic       in_valid1, in_ready1, out_valid1, out_ready1, out_borrow1, out_zero1;
  logic [7:0] in_a1, in_b1, sub_din1_1, sub_din2_1, sub_dout1, out_diff1;
  logic [7:0] p1, p2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sub_operand_sequencer #(.DWIDTH(8), .SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .sub_din1(sub_din1), .sub_din2(sub_din2),
    .sub_dout(sub_dout), .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_borrow(out_borrow), .out_zero(out_zero)
  );

  sub_operand_sequencer #(.DWIDTH(8), .SETTLE_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .sub_din1(sub_din1_1), .sub_din2(sub_din2_1),
    .sub_dout(sub_dout1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_diff(out_diff1), .out_borrow(out_borrow1), .out_zero(out_zero1)
  );

  // Subtractor models: one-edge latency for dut0, three-edge pipeline for dut1
  always @(posedge clk) begin
    sub_dout  <= sub_din1 - sub_din2;
    p1        <= sub_din1_1 - sub_din2_1;
    p2        <= p1;
    sub_dout1 <= p2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One operation on dut0; stall = cycles out_ready stays low after out_valid
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall);
    logic [7:0] ed;
    logic       eb, ez;
    int         lat;
    ed  = a - b;
    eb  = (a < b);
    ez  = (ed == 8'd0);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      chk("hold_din1", sub_din1, 32'(a));
      chk("hold_din2", sub_din2, 32'(b));
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("latency", lat, 32'd2);
    chk("diff", out_diff, 32'(ed));
    chk("borrow", out_borrow, 32'(eb));
    chk("zero", out_zero, 32'(ez));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
      @(negedge clk);
      chk("stall_valid", out_valid, 32'd1);
      chk("stall_diff", out_diff, 32'(ed));
      chk("stall_borrow", out_borrow, 32'(eb));
      chk("stall_in_ready", in_ready, 32'd0);
      chk("stall_din1", sub_din1, 32'(a));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("retire_valid", out_valid, 32'd0);
    chk("retire_in_ready", in_ready, 32'd1);
    chk("retire_diff_kept", out_diff, 32'(ed));
    chk("retire_din2", sub_din2, 32'(b));
    out_ready = 1'b0;
  endtask

  // One operation on dut1 with out_ready held high throughout
  task automatic run_op3(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] ed;
    int         lat;
    ed = a - b;
    @(negedge clk);
    chk("d1_in_ready", in_ready1, 32'd1);
    in_valid1 = 1'b1; in_a1 = a; in_b1 = b; out_ready1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid1) break;
      @(posedge clk);
      lat++;
    end
    chk("d1_latency", lat, 32'd4);
    chk("d1_diff", out_diff1, 32'(ed));
    chk("d1_borrow", out_borrow1, 32'(a < b));
    chk("d1_zero", out_zero1, 32'(ed == 8'd0));
    @(negedge clk);
    chk("d1_retire", out_valid1, 32'd0);
  endtask

  initial begin
    int         lat;
    logic       any_valid;
    logic [7:0] ra, rb;
    rst = 1'b0; rst1 = 1'b0;
    in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_a1 = 8'd0; in_b1 = 8'd0; out_ready1 = 1'b0;

    // Reset asserted mid-cycle takes effect immediately
    #2 rst = 1'b1; rst1 = 1'b1;
    #1;
    chk("rst_din1", sub_din1, 32'd0);
    chk("rst_din2", sub_din2, 32'd0);
    chk("rst_diff", out_diff, 32'd0);
    chk("rst_flags", {out_borrow, out_zero, out_valid}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 32'd1);
    chk("post_rst_valid", out_valid, 32'd0);

    // Directed single op, wrap with borrow, zero result
    run_op(8'd100, 8'd37, 0);
    run_op(8'd5, 8'd9, 0);
    run_op(8'h5A, 8'h5A, 0);

    // Async reset clears a presented-but-retired result mid-cycle
    @(negedge clk); #3 rst = 1'b1; #1;
    chk("rst2_diff", out_diff, 32'd0);
    chk("rst2_din1", sub_din1, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Backpressure for 5 cycles
    run_op(8'd77, 8'd200, 5);

    // Back-to-back: second pair launches on the edge the first retires
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'd200; in_b = 8'd1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_a = 8'd3; in_b = 8'd4;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("b2b_lat1", lat, 32'd2);
    chk("b2b_diff1", out_diff, 32'd199);
    chk("b2b_borrow1", out_borrow, 32'd0);
    chk("b2b_in_ready", in_ready, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (lat == 1) chk("b2b_launch_din1", sub_din1, 32'd3);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("b2b_interval", lat, 32'd3);
    chk("b2b_diff2", out_diff, 32'd255);
    chk("b2b_borrow2", out_borrow, 32'd1);
    @(negedge clk);
    chk("b2b_retire", out_valid, 32'd0);
    out_ready = 1'b0;

    // Randomized operations against the arithmetic reference
    for (int k = 0; k < 24; k++) begin
      ra = 8'($urandom);
      rb = (k % 6 == 0) ? ra : 8'($urandom);
      run_op(ra, rb, int'($urandom_range(0, 3)));
    end

    // SETTLE_CYCLES=3: reset mid-WAIT discards the op
    @(negedge clk);
    in_valid1 = 1'b1; in_a1 = 8'd10; in_b1 = 8'd2; out_ready1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(posedge clk); #2;
    rst1 = 1'b1; #1;
    chk("d1_rst_valid", out_valid1, 32'd0);
    chk("d1_rst_din1", sub_din1_1, 32'd0);
    @(negedge clk); rst1 = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      any_valid = any_valid | out_valid1;
    end
    chk("d1_no_partial", any_valid, 32'd0);
    run_op3(8'd7, 8'd7);
    for (int k = 0; k < 4; k++) run_op3(8'($urandom), 8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
